// File: rtl/auc_pkg.sv
// Shared definitions for the X25519 ladder front end: operand RAM map,
// curve constant, init-loader state encoding and the byte-order helper.
package auc_pkg;

  localparam int unsigned AUC_WID   = 256;
  localparam int unsigned AUC_AWID  = 5;
  localparam int unsigned AUC_NBYTE = AUC_WID / 8;

  localparam logic [AUC_WID-1:0] AUC_A24VAL = AUC_WID'(121665);

  // Operand RAM address map
  localparam logic [AUC_AWID-1:0] X_G      = AUC_AWID'(0);
  localparam logic [AUC_AWID-1:0] X2       = AUC_AWID'(7);
  localparam logic [AUC_AWID-1:0] Z2       = AUC_AWID'(8);
  localparam logic [AUC_AWID-1:0] X3       = AUC_AWID'(9);
  localparam logic [AUC_AWID-1:0] Z3       = AUC_AWID'(10);
  localparam logic [AUC_AWID-1:0] K_NUM    = AUC_AWID'(11);
  localparam logic [AUC_AWID-1:0] ZRRAM    = AUC_AWID'(18);
  localparam logic [AUC_AWID-1:0] ONERAM   = AUC_AWID'(19);
  localparam logic [AUC_AWID-1:0] ACCIDENT = AUC_AWID'(30);
  localparam logic [AUC_AWID-1:0] A24      = AUC_AWID'(31);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WAITK = 3'd1,
    ST_WRK   = 3'd2,
    ST_WAITU = 3'd3,
    ST_WRU   = 3'd4,
    ST_DONE  = 3'd5
  } init_st_e;

  // Little-endian byte string (byte 0 in the top byte lane) to integer order
  function automatic logic [AUC_WID-1:0] byte_rev(input logic [AUC_WID-1:0] x);
    logic [AUC_WID-1:0] r;
    r = '0;
    for (int i = 0; i < int'(AUC_NBYTE); i++) begin
      r[8*i +: 8] = x[AUC_WID-1-8*i -: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/auc_mmulinit_if.sv
// Input word handshake into the init loader.
//   in_vld/in_sel/in_dat : word valid, type (0 scalar, 1 u), RFC 7748 byte string
//   in_rdy               : loader ready; transfer = in_vld & in_rdy at posedge
interface auc_mmulinit_if
  import auc_pkg::*;
#(
  parameter int unsigned WID = AUC_WID
);
  logic           in_vld;
  logic           in_rdy;
  logic           in_sel;
  logic [WID-1:0] in_dat;

  modport master (output in_vld, output in_sel, output in_dat, input in_rdy);
  modport slave  (input in_vld, input in_sel, input in_dat, output in_rdy);
endinterface

// File: rtl/auc_bytedec.sv
// Byte-reverses an RFC 7748 string into an integer, always clears bit 255,
// and with clamp_i set applies the scalar clamp (bits 2:0 cleared, bit 254 set).
//   dat_i   : byte string
//   clamp_i : 1 = scalar clamp, 0 = u-coordinate mask only
//   dec_c   : decoded value (combinational)
module auc_bytedec
  import auc_pkg::*;
(
  input  logic [AUC_WID-1:0] dat_i,
  input  logic               clamp_i,
  output logic [AUC_WID-1:0] dec_c
);

  always_comb begin
    dec_c            = byte_rev(dat_i);
    dec_c[AUC_WID-1] = 1'b0;
    if (clamp_i) begin
      dec_c[AUC_WID-2] = 1'b1;
      dec_c[2:0]       = 3'b000;
    end
  end

endmodule

// File: rtl/auc_mmulinit.sv
// X25519 ladder init loader: accepts scalar then u, decodes them and writes
// scalar, u and the ladder start constants into the operand RAM, then
// releases the ladder sequencer with a one-cycle init_done.
//   clk, rst         : clock, async active-low reset
//   init_en          : start pulse, honoured only when idle
//   in_bus           : input word handshake (slave side)
//   init_err         : pulse, accepted word had the wrong type
//   init_done        : pulse, all RAM writes issued
//   init_we/wa/wd    : registered RAM write port
module auc_mmulinit
  import auc_pkg::*;
#(
  parameter int unsigned    WID    = AUC_WID,
  parameter int unsigned    AWID   = AUC_AWID,
  parameter logic [WID-1:0] A24VAL = AUC_A24VAL
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             init_en,
  auc_mmulinit_if.slave    in_bus,
  output logic             init_err,
  output logic             init_done,
  output logic [AWID-1:0]  init_wa,
  output logic             init_we,
  output logic [WID-1:0]   init_wd
);

  init_st_e       state_q, state_d;
  logic [2:0]     cnt_q, cnt_d;
  logic [WID-1:0] k_q, k_d, u_q, u_d, wd_q, wd_d;
  logic [AWID-1:0] wa_q, wa_d;
  logic           we_q, we_d, err_q, err_d, done_q, done_d, rdy_q, rdy_d;
  logic [WID-1:0] k_dec_c, u_dec_c;
  logic           xfer_c;

  auc_bytedec u_kdec (.dat_i(in_bus.in_dat), .clamp_i(1'b1), .dec_c(k_dec_c));
  auc_bytedec u_udec (.dat_i(in_bus.in_dat), .clamp_i(1'b0), .dec_c(u_dec_c));

  // in_rdy is a registered decode of the state, so it never depends on in_vld
  assign xfer_c = in_bus.in_vld & rdy_q;

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 3'd0;
      k_q     <= '0;
      u_q     <= '0;
      wd_q    <= '0;
      wa_q    <= AWID'(ACCIDENT);
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
      u_q     <= u_d;
      wd_q    <= wd_d;
      wa_q    <= wa_d;
      we_q    <= we_d;
      err_q   <= err_d;
      done_q  <= done_d;
      rdy_q   <= rdy_d;
    end
  end

  // Next-state and registered-output decode
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    u_d     = u_q;
    wd_d    = wd_q;
    wa_d    = AWID'(ACCIDENT);
    we_d    = 1'b0;
    err_d   = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: if (init_en) state_d = ST_WAITK;
      ST_WAITK: if (xfer_c) begin
        if (!in_bus.in_sel) begin
          k_d     = k_dec_c;
          state_d = ST_WRK;
        end else begin
          err_d = 1'b1;
        end
      end
      ST_WRK: begin
        we_d    = 1'b1;
        wa_d    = AWID'(K_NUM);
        wd_d    = k_q;
        state_d = ST_WAITU;
      end
      ST_WAITU: if (xfer_c) begin
        if (in_bus.in_sel) begin
          u_d     = u_dec_c;
          cnt_d   = 3'd0;
          state_d = ST_WRU;
        end else begin
          err_d = 1'b1;
        end
      end
      ST_WRU: begin
        we_d  = 1'b1;
        cnt_d = cnt_q + 3'd1;
        case (cnt_q)
          3'd0: begin wa_d = AWID'(X3);     wd_d = u_q;        end
          3'd1: begin wa_d = AWID'(X_G);    wd_d = u_q;        end
          3'd2: begin wa_d = AWID'(X2);     wd_d = WID'(1);    end
          3'd3: begin wa_d = AWID'(Z2);     wd_d = '0;         end
          3'd4: begin wa_d = AWID'(Z3);     wd_d = WID'(1);    end
          3'd5: begin wa_d = AWID'(ONERAM); wd_d = WID'(1);    end
          3'd6: begin wa_d = AWID'(ZRRAM);  wd_d = '0;         end
          default: begin
            wa_d    = AWID'(A24);
            wd_d    = A24VAL;
            state_d = ST_DONE;
          end
        endcase
      end
      ST_DONE: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    rdy_d = (state_d == ST_WAITK) || (state_d == ST_WAITU);
  end

  assign in_bus.in_rdy = rdy_q;
  assign init_err      = err_q;
  assign init_done     = done_q;
  assign init_we       = we_q;
  assign init_wa       = wa_q;
  assign init_wd       = wd_q;

endmodule

// File: tb/tb_auc_mmulinit.sv
// Randomized bench for the X25519 init loader with a transaction-level model.
module tb_auc_mmulinit;
  import auc_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         init_en = 1'b0;
  logic         init_err, init_done, init_we;
  logic [4:0]   init_wa;
  logic [255:0] init_wd;

  auc_mmulinit_if bus ();

  auc_mmulinit dut (
    .clk(clk), .rst(rst), .init_en(init_en), .in_bus(bus.slave),
    .init_err(init_err), .init_done(init_done),
    .init_wa(init_wa), .init_we(init_we), .init_wd(init_wd)
  );

  always #5 clk = ~clk;

  typedef struct { int c; logic [4:0] a; logic [255:0] d; } wr_t;
  wr_t          wq[$];
  int           cyc = 0;
  int           phase = 0;           // 0 idle/busy, 1 waiting scalar, 2 waiting u
  int           rdy_from = 0, idle_from = 0, exp_done = -1, exp_err = -1;
  int           last_xfer = 0, last_done = -1;
  logic [255:0] last_wd = '0;
  logic [255:0] seen [32];
  int           n_vec = 0, n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, exp);
    end
  endtask

  // Integer value of a little-endian byte string
  function automatic logic [255:0] m_decode(input logic [255:0] s);
    logic [255:0] r = '0;
    for (int j = 31; j >= 0; j--) r = (r << 8) | 256'(s[255-8*j -: 8]);
    return r;
  endfunction
  function automatic logic [255:0] m_clamp(input logic [255:0] s);
    logic [255:0] r = m_decode(s);
    r = r & ~256'd7;
    r = r & ~(256'd1 << 255);
    return r | (256'd1 << 254);
  endfunction
  function automatic logic [255:0] m_umask(input logic [255:0] s);
    return m_decode(s) & ~(256'd1 << 255);
  endfunction
  function automatic logic model_rdy(input int c);
    return (phase == 1 || phase == 2) && c >= rdy_from;
  endfunction
  function automatic logic [255:0] rnd256();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  // Compare process: every cycle against the model
  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_rdy", 256'(bus.in_rdy), 256'd0);
      chk("rst_we", 256'(init_we), 256'd0);
      chk("rst_wa", 256'(init_wa), 256'd30);
      chk("rst_wd", init_wd, 256'd0);
      chk("rst_done", 256'(init_done), 256'd0);
      chk("rst_err", 256'(init_err), 256'd0);
    end else begin
      chk("in_rdy", 256'(bus.in_rdy), 256'(model_rdy(cyc)));
      chk("init_err", 256'(init_err), 256'(cyc == exp_err));
      chk("init_done", 256'(init_done), 256'(cyc == exp_done));
      if (init_done) last_done = cyc;
      if (wq.size() > 0 && wq[0].c == cyc) begin
        chk("wr_we", 256'(init_we), 256'd1);
        chk("wr_wa", 256'(init_wa), 256'(wq[0].a));
        chk("wr_wd", init_wd, wq[0].d);
        seen[init_wa] = init_wd;
        last_wd = wq[0].d;
        void'(wq.pop_front());
      end else begin
        chk("idle_we", 256'(init_we), 256'd0);
        chk("idle_wa", 256'(init_wa), 256'd30);
        chk("idle_wd", init_wd, last_wd);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    wq.delete();
    phase = 0; idle_from = 0; exp_done = -1; exp_err = -1; last_wd = '0;
  endtask

  task automatic pulse_init();
    logic acc;
    init_en = 1'b1;
    acc = (phase == 0) && (cyc >= idle_from);
    tick();
    init_en = 1'b0;
    if (acc) begin phase = 1; rdy_from = cyc; end
  endtask

  task automatic send(input logic sel, input logic [255:0] d);
    int n = 0;
    logic [255:0] u;
    bus.in_vld = 1'b1; bus.in_sel = sel; bus.in_dat = d;
    while (!model_rdy(cyc) && n < 50) begin tick(); n++; end
    if (n >= 50) begin
      chk("send_timeout", 256'd0, 256'd1);
      bus.in_vld = 1'b0;
      return;
    end
    tick();
    bus.in_vld = 1'b0;
    last_xfer = cyc;
    if (phase == 1 && sel == 1'b0) begin
      wq.push_back('{cyc + 1, 5'd11, m_clamp(d)});
      phase = 2; rdy_from = cyc + 1;
    end else if (phase == 2 && sel == 1'b1) begin
      u = m_umask(d);
      wq.push_back('{cyc + 1, 5'd9,  u});
      wq.push_back('{cyc + 2, 5'd0,  u});
      wq.push_back('{cyc + 3, 5'd7,  256'd1});
      wq.push_back('{cyc + 4, 5'd8,  256'd0});
      wq.push_back('{cyc + 5, 5'd10, 256'd1});
      wq.push_back('{cyc + 6, 5'd19, 256'd1});
      wq.push_back('{cyc + 7, 5'd18, 256'd0});
      wq.push_back('{cyc + 8, 5'd31, 256'd121665});
      phase = 0; idle_from = cyc + 9; exp_done = cyc + 9;
    end else begin
      exp_err = cyc;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (cyc <= idle_from && n < 50) begin tick(); n++; end
  endtask

  logic [255:0] kv, uv, tmp;

  initial begin
    bus.in_vld = 1'b0; bus.in_sel = 1'b0; bus.in_dat = '0;
    for (int i = 0; i < 32; i++) seen[i] = '0;
    model_reset();
    repeat (3) tick();
    rst = 1'b1;
    tick();

    // in_vld with in_rdy low while idle: nothing happens
    for (int i = 0; i < 3; i++) begin
      bus.in_vld = 1'b1; bus.in_sel = 1'($urandom); bus.in_dat = rnd256();
      tick();
    end
    bus.in_vld = 1'b0;

    // RFC 7748 vector 1
    kv = 256'ha546e36bf0527c9d3b16154b82465edd62144c0ac1fc5a18506a2244ba449ac4;
    uv = 256'he6db6867583030db3594c1a424b15f7c726624ec26b3353b10a903a6d0ab1c4c;
    tmp = m_clamp(kv);
    chk("model_k_lsb", 256'(tmp[7:0]), 256'h a0);
    pulse_init();
    send(1'b0, kv);
    send(1'b1, uv);
    wait_idle();
    tmp = seen[11];
    chk("rfc_k_lsb", 256'(tmp[7:0]), 256'ha0);
    chk("rfc_k_msb", 256'(tmp[255:248]), 256'h44);
    tmp = seen[9];
    chk("rfc_x3_lsb", 256'(tmp[7:0]), 256'he6);
    chk("rfc_x3_msb", 256'(tmp[255:248]), 256'h4c);
    chk("rfc_xg", seen[0], seen[9]);
    chk("rfc_a24", seen[31], 256'd121665);
    chk("rfc_done_lat", 256'(last_done - last_xfer), 256'd9);

    // u word presented while waiting for the scalar, then saturating values
    pulse_init();
    send(1'b1, rnd256());
    chk("err_rdy_held", 256'(bus.in_rdy), 256'd1);
    send(1'b0, {256{1'b1}});
    tmp = rnd256();
    tmp[7:0] = 8'hff;
    send(1'b1, tmp);
    wait_idle();
    chk("k_all_ff", seen[11], {8'h7f, {30{8'hff}}, 8'hf8});
    tmp = seen[9];
    chk("u_bit255_mask", 256'(tmp[255:248]), 256'h7f);

    // init_en and in_vld noise during WRU, then back-to-back restart
    pulse_init();
    send(1'b0, rnd256());
    send(1'b1, rnd256());
    while (cyc < idle_from - 1) begin
      bus.in_vld = 1'b1; bus.in_sel = 1'($urandom); bus.in_dat = rnd256();
      init_en = 1'($urandom);
      tick();
    end
    init_en = 1'b0; bus.in_vld = 1'b0;
    tick();
    chk("b2b_done_hi", 256'(init_done), 256'd1);
    pulse_init();
    chk("b2b_rdy", 256'(bus.in_rdy), 256'd1);
    send(1'b0, rnd256());
    send(1'b1, rnd256());
    wait_idle();

    // Reset during WRU at cnt=3, then a full run
    pulse_init();
    send(1'b0, rnd256());
    send(1'b1, rnd256());
    while (cyc < last_xfer + 3) tick();
    rst = 1'b0;
    model_reset();
    #1;
    chk("midrst_we", 256'(init_we), 256'd0);
    chk("midrst_wa", 256'(init_wa), 256'd30);
    repeat (2) tick();
    rst = 1'b1;
    repeat (12) tick();
    pulse_init();
    send(1'b0, rnd256());
    send(1'b1, rnd256());
    wait_idle();
    chk("post_rst_done_lat", 256'(last_done - last_xfer), 256'd9);

    // Randomized sequences with occasional wrong-type words
    for (int it = 0; it < 10; it++) begin
      pulse_init();
      if (it == 0 || $urandom_range(3) == 0) send(1'b1, rnd256());
      send(1'b0, rnd256());
      if (it == 1 || $urandom_range(3) == 0) send(1'b0, rnd256());
      send(1'b1, rnd256());
      repeat ($urandom_range(3)) tick();
      wait_idle();
    end
    repeat (3) tick();
    chk("queue_drained", 256'(wq.size()), 256'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule

// File: doc/auc_mmulinit.md
Name: auc_mmulinit

Overview:
Input decoder and loader for the X25519 Montgomery-ladder core. It accepts the scalar and the u-coordinate as RFC 7748 byte strings and byte-reverses them into integer order. It clamps the scalar, masks bit 255 of u, then writes the scalar, u and the ladder initial constants into the operand block RAM. It sits ahead of the ladder sequencer, which it releases with init_done; it is the write-side counterpart of the final-result encoder.

Parameters:
WID, 256, operand width / RAM data width
AWID, 5, RAM address width
A24VAL, 121665, curve constant written to address A24

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low (0 = reset)
init_en  in  1  start pulse from controller; ignored unless IDLE
in_vld  in  1  input word valid
in_rdy  out  1  input word ready; transfer = in_vld & in_rdy at posedge
in_sel  in  1  word type: 0 = scalar, 1 = u-coordinate
in_dat  in  WID  byte string; in_dat[255:248] = byte 0 (least significant byte of the integer)
init_err  out  1  one-cycle pulse: accepted word had wrong in_sel
init_done  out  1  one-cycle pulse: all RAM writes complete
init_wa  out  AWID  RAM write address
init_we  out  1  RAM write enable
init_wd  out  WID  RAM write data

Behaviour:
- Reset (rst=0, async): state IDLE, cnt=0, in_rdy=0, init_we=0, init_wa=30 (ACCIDENT), init_wd=0, init_err=0, init_done=0, captured registers=0. Reset mid-operation aborts without completing writes; the next init_en restarts from WAITK.
- Decode: integer byte i = in_dat[(32-i)*8-1 -: 8], for i=0..31.
- Scalar clamp (after decode): clear bits 2:0, clear bit 255, set bit 254.
- u mask (after decode): clear bit 255.
- States: IDLE, WAITK, WRK, WAITU, WRU, DONE.
- IDLE: if init_en, go to WAITK. init_en in any other state is ignored.
- WAITK: in_rdy=1 (combinational from state; never depends on in_vld).
  - Transfer with in_sel=0: capture clamped scalar, go to WRK.
  - Transfer with in_sel=1: word dropped, init_err pulses in the next cycle, state unchanged.
- WRK: one cycle; go to WAITU. Registered outputs in the next cycle: we=1, wa=11 (K_NUM), wd=scalar.
- WAITU: in_rdy=1.
  - Transfer with in_sel=1: capture masked u, cnt=0, go to WRU.
  - in_sel=0: dropped, init_err pulse.
- WRU: 8 cycles, cnt 0..7. Each cycle produces one registered write in the next cycle:
  - cnt=0: wa=9 (X3), wd=u
  - cnt=1: wa=0 (X_G), wd=u
  - cnt=2: wa=7 (X2), wd=1
  - cnt=3: wa=8 (Z2), wd=0
  - cnt=4: wa=10 (Z3), wd=1
  - cnt=5: wa=19 (ONERAM), wd=1
  - cnt=6: wa=18 (ZRRAM), wd=0
  - cnt=7: wa=31 (A24), wd=A24VAL, then go to DONE.
- DONE: init_done=1 in the next cycle; state returns to IDLE.
- Write outputs are registered. init_we is high exactly 1 cycle for K, then exactly 8 consecutive cycles for the WRU writes. When not writing: init_we=0, init_wa=30, init_wd holds its last value.
- Latency:
  - scalar transfer edge to K write: 1 cycle.
  - u transfer edge to first WRU write: 1 cycle.
  - u transfer edge to init_done: 9 cycles.
- in_rdy is 0 in IDLE, WRK, WRU and DONE.
- Back-to-back: a new init_en arriving in the same cycle init_done is high is accepted (state is IDLE then).

Decomposition:
- Shared package auc_pkg: RAM address localparams (X_G, X2, Z2, X3, Z3, K_NUM, ONERAM, ZRRAM, ACCIDENT, A24), A24VAL, the byte-reverse function (also reused by the final-result encoder), and the init state encoding.
- One sub-module, auc_bytedec: combinational byte reversal plus an optional clamp/mask selected by an input bit. Two instances: one for the scalar, one for u.

Test Plan:
- RFC 7748 vector 1: scalar a546…449ac4 (sel=0), then u e6db…ab1c4c (sel=1) -> K_NUM LS byte 0xa0, MS byte 0x44; X3 = X_G = decoded u; writes in order 11, 9, 0, 7, 8, 10, 19, 18, 31 with data K, u, u, 1, 0, 1, 1, 0, 121665; init_done exactly 9 cycles after the u transfer.
- u byte 31 = 0xff -> X3 MS byte 0x7f; scalar of all 0xff -> K_NUM = 0x7fff…fff8.
- u word (sel=1) presented in WAITK -> init_err one pulse, no write, in_rdy stays 1; then scalar accepted normally.
- in_vld held high with in_rdy low (IDLE, WRU) -> no transfer, no write; init_en pulses during WRU -> ignored, sequence unchanged.
- rst=0 asserted during WRU at cnt=3 -> init_we=0 and init_wa=30 immediately; no init_done; a subsequent init_en runs the full sequence.
- init_en asserted in the same cycle init_done is high -> in_rdy rises the next cycle.
